elevator_ctrl_n: RTL and testbench
==================================

// Module: elevator_ctrl_n
// PURPOSE
//  Parametrised N-floor elevator controller; successor to the fixed 3-floor elevator block.
//  - Latches hall up/down calls and in-car floor calls into pending registers.
//  - Uses collective (SCAN) dispatch from the floor-sensor position; drives direction and door.
//  - Times the door dwell. Door-close (dc) button shortens the dwell; obstruction (door sensor) extends it.
// PARAMETERS
//  NUM_FLOORS        4   floor count, >=2; floors indexed 0..NUM_FLOORS-1
//  DOOR_OPEN_CYCLES  8   door dwell in clk cycles, >=2
//  FLW               $clog2(NUM_FLOORS)  floor index width (localparam, min 1)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous reset, active high
//  hall_up    in   NUM_FLOORS hall up buttons; bit NUM_FLOORS-1 ignored
//  hall_dn    in   NUM_FLOORS hall down buttons; bit 0 ignored
//  car_call   in   NUM_FLOORS in-car floor buttons
//  dc         in   1          door-close button
//  obstruct   in   1          door sensor, 1 = doorway blocked
//  fs         in   FLW        floor sensor: index of floor car is aligned with
//  fs_valid   in   1          1 = car level with floor fs
//  door       out  1          1 = door open command
//  dir        out  2          motor direction: 00 idle, 01 up, 10 down (11 never driven)
//  up_lamp    out  NUM_FLOORS pending hall-up calls
//  dn_lamp    out  NUM_FLOORS pending hall-down calls
//  car_lamp   out  NUM_FLOORS pending car calls
//  fault      out  1          sticky: fs_valid with fs >= NUM_FLOORS seen
// BEHAVIOUR
//  Reset (any time, incl. mid-travel or door open):
//   - Outputs: door=0, dir=00, fault=0; all lamps/pending cleared.
//   - Internal: state=IDLE, last_dir=UP, timer=0.
//  Call capture:
//   - A button high in cycle N sets its pending bit; visible on lamps at N+1.
//   - Calls are level-sampled; holding a button is harmless.
//   - Calls at the current floor while the door is open, in last_dir or a car call: not latched; the timer reloads instead.
//   - Outcome at any stop: after the door closes there is no pending call at the current floor.
//  Definitions (at fs): above = any pending above fs; below = any pending below fs; here = any pending at fs.
//  FSM (outputs registered, 1-cycle latency from decision):
//   - IDLE: dir=00, door=0. Needs fs_valid. Priority: here -> DOOR_OPEN; above -> MOVE_UP; below -> MOVE_DN.
//   - MOVE_UP: dir=01. Stop when fs_valid and one of:
//       car_call[fs]; or hall_up[fs]; or (!above and hall_dn[fs]); or fs==NUM_FLOORS-1 (forced).
//     On stop: -> DOOR_OPEN, dir=00 in the same cycle door=1.
//   - MOVE_DN: mirror of MOVE_UP; forced stop at fs==0.
//   - DOOR_OPEN entry:
//       - Clears car_call[fs] and the hall call in last_dir at fs.
//       - If nothing is pending further in last_dir, also clears the opposite hall call at fs and flips last_dir.
//       - Timer loads DOOR_OPEN_CYCLES-1 and decrements each cycle.
//   - DOOR_OPEN timer events:
//       - obstruct=1: timer reloads, door held (overrides dc).
//       - dc=1 with timer>0 and !obstruct: timer forced to 0.
//       - timer==0 && !obstruct: door=0 next cycle. Next state: last_dir if pending there, else opposite, else IDLE.
//  Boundaries:
//   - fs_valid=0 while moving: keep dir, no stop decision.
//   - fs_valid with fs>=NUM_FLOORS: set fault, force dir=00, state=IDLE. Calls keep latching; no dispatch until rst.
//   - Simultaneous calls above and below from IDLE: go up.
//   - dir never switches 01<->10 without at least one dir=00 cycle.
// STRUCTURE
//  - elevator_pkg: dir_t enum (DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DN=2'b10) and state_t enum (IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN).
//  - elevator_pkg also holds the function any_above(mask, fs) and its mirror any_below.
//  - Sub-module elevator_door_timer: load/reload/force-zero down-counter, done flag.
//  - This module holds call registers, FSM and stop logic.
// TESTING  (NUM_FLOORS=4, DOOR_OPEN_CYCLES=8)
//  1. Reset while dir=01: assert rst mid-cycle -> door=0, dir=00 and all lamps 0 immediately; IDLE after release.
//  2. Idle at fs=0, car_call[3] pulse -> car_lamp=4'b1000 next cycle, dir=01.
//     Then sweep fs 1,2,3 -> stop at 3; door=1 for 8 cycles; lamp cleared.
//  3. Moving up past fs=1, hall_up[2] and hall_dn[1] set -> stops at 2 only.
//     Then reverses to floor 1 (dir 00 then 10); hall_dn[1] served.
//  4. Door open at fs=2: obstruct high 5 cycles -> door stays 1 for 5+8 cycles after release.
//     dc pulse on 2nd open cycle with obstruct=0 -> door=0 next cycle.
//  5. Calls at floors 3 and 0 together from IDLE at fs=1 -> goes up first, serves 3, then goes down to 0.
//  6. fs_valid=1, fs=3 with NUM_FLOORS=3 -> fault=1 sticky, dir=00; clears only on rst.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and call-mask helpers for the elevator controller
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DN,
        DOOR_OPEN
    } state_t;

    // Call masks are zero-extended to this width before calling the helpers
    localparam int MAX_FLOORS = 32;

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask, input int fs);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > fs) r = r | mask[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask, input int fs);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < fs) r = r | mask[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_if.sv
// rtl/elevator_if.sv - elevator controller pin bundle with master/slave modports
interface elevator_if #(
    parameter int NUM_FLOORS = 4
);
    localparam int FLW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1;

    logic [NUM_FLOORS-1:0] hall_up;
    logic [NUM_FLOORS-1:0] hall_dn;
    logic [NUM_FLOORS-1:0] car_call;
    logic                  dc;
    logic                  obstruct;
    logic [FLW-1:0]        fs;
    logic                  fs_valid;
    logic                  door;
    logic [1:0]            dir;
    logic [NUM_FLOORS-1:0] up_lamp;
    logic [NUM_FLOORS-1:0] dn_lamp;
    logic [NUM_FLOORS-1:0] car_lamp;
    logic                  fault;

    modport master (
        output hall_up, hall_dn, car_call, dc, obstruct, fs, fs_valid,
        input  door, dir, up_lamp, dn_lamp, car_lamp, fault
    );

    modport slave (
        input  hall_up, hall_dn, car_call, dc, obstruct, fs, fs_valid,
        output door, dir, up_lamp, dn_lamp, car_lamp, fault
    );
endinterface

// File: rtl/elevator_door_timer.sv
// rtl/elevator_door_timer.sv - door dwell down-counter with load/reload and force-to-zero
module elevator_door_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic force_zero,
    output logic done
);
    localparam int            TW   = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TMAX;
        end else if (force_zero) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor collective (SCAN) elevator controller: call latches, stop logic, door FSM
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS       = 4,
    parameter int DOOR_OPEN_CYCLES = 8
) (
    input  logic      clk,
    input  logic      rst,
    elevator_if.slave bus
);
    localparam int                    FLW    = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1;
    localparam logic [NUM_FLOORS-1:0] UP_OK  = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_OK  = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [NUM_FLOORS-1:0] ONE    = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FLW:0]          NF_EXT = (FLW+1)'(NUM_FLOORS);
    localparam logic [FLW-1:0]        TOP    = FLW'(NUM_FLOORS - 1);

    state_t state;
    dir_t   dir_q;
    logic   door_q, fault_q, last_up;
    logic [NUM_FLOORS-1:0] up_pend, dn_pend, car_pend;
    logic [NUM_FLOORS-1:0] up_new, dn_new, car_new, cap_up, cap_dn, cap_car, all_cap, at_fs;
    logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
    logic fs_bad, fs_in, above, below, here, further, stop_up, stop_dn, enter_door;
    logic door_sup, call_reload, t_load, t_zero, t_done, expire;

    assign fs_bad = bus.fs_valid && ({1'b0, bus.fs} >= NF_EXT);
    assign fs_in  = bus.fs_valid && !fs_bad;
    assign at_fs  = ONE << bus.fs;

    // With the door open, a press that this stop already serves only re-arms the dwell
    assign door_sup    = (state == DOOR_OPEN) && fs_in;
    assign car_new     = bus.car_call & ~(door_sup ? at_fs : '0);
    assign up_new      = bus.hall_up & UP_OK & ~((door_sup && last_up) ? at_fs : '0);
    assign dn_new      = bus.hall_dn & DN_OK & ~((door_sup && !last_up) ? at_fs : '0);
    assign call_reload = door_sup &&
        |((bus.car_call | (last_up ? (bus.hall_up & UP_OK) : (bus.hall_dn & DN_OK))) & at_fs);

    assign cap_up  = up_pend | up_new;
    assign cap_dn  = dn_pend | dn_new;
    assign cap_car = car_pend | car_new;
    assign all_cap = cap_up | cap_dn | cap_car;

    assign above   = any_above(MAX_FLOORS'(all_cap), int'(bus.fs));
    assign below   = any_below(MAX_FLOORS'(all_cap), int'(bus.fs));
    assign here    = |(all_cap & at_fs);
    assign further = last_up ? above : below;

    assign stop_up = |((cap_car | cap_up | (above ? '0 : cap_dn)) & at_fs) || (bus.fs == TOP);
    assign stop_dn = |((cap_car | cap_dn | (below ? '0 : cap_up)) & at_fs) || (bus.fs == '0);

    assign enter_door = fs_in && ((state == IDLE && !fault_q && here) ||
                                  (state == MOVE_UP && stop_up) ||
                                  (state == MOVE_DN && stop_dn));

    // A stop with nothing further ahead serves both hall calls here and turns around
    assign clr_car = enter_door ? at_fs : '0;
    assign clr_up  = (enter_door && (last_up || !further)) ? at_fs : '0;
    assign clr_dn  = (enter_door && (!last_up || !further)) ? at_fs : '0;

    assign t_load = enter_door || (state == DOOR_OPEN && (bus.obstruct || call_reload));
    assign t_zero = (state == DOOR_OPEN) && bus.dc && !bus.obstruct && !t_done;
    assign expire = (state == DOOR_OPEN) && !bus.obstruct && !call_reload && (t_done || bus.dc);

    elevator_door_timer #(.CYCLES(DOOR_OPEN_CYCLES)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (t_load),
        .force_zero (t_zero),
        .done       (t_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dir_q    <= DIR_IDLE;
            door_q   <= 1'b0;
            fault_q  <= 1'b0;
            last_up  <= 1'b1;
            up_pend  <= '0;
            dn_pend  <= '0;
            car_pend <= '0;
        end else begin
            up_pend  <= cap_up & ~clr_up;
            dn_pend  <= cap_dn & ~clr_dn;
            car_pend <= cap_car & ~clr_car;
            if (fs_bad) begin
                fault_q <= 1'b1;
                state   <= IDLE;
                dir_q   <= DIR_IDLE;
                door_q  <= 1'b0;
            end else if (enter_door) begin
                state  <= DOOR_OPEN;
                dir_q  <= DIR_IDLE;
                door_q <= 1'b1;
                if (!further) last_up <= !last_up;
            end else begin
                case (state)
                    IDLE: if (fs_in && !fault_q) begin
                        if (above) begin
                            state   <= MOVE_UP;
                            dir_q   <= DIR_UP;
                            last_up <= 1'b1;
                        end else if (below) begin
                            state   <= MOVE_DN;
                            dir_q   <= DIR_DN;
                            last_up <= 1'b0;
                        end
                    end
                    DOOR_OPEN: if (expire) begin
                        door_q <= 1'b0;
                        if (further) begin
                            state <= last_up ? MOVE_UP : MOVE_DN;
                            dir_q <= last_up ? DIR_UP : DIR_DN;
                        end else if (last_up ? below : above) begin
                            state   <= last_up ? MOVE_DN : MOVE_UP;
                            dir_q   <= last_up ? DIR_DN : DIR_UP;
                            last_up <= !last_up;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.door     = door_q;
    assign bus.dir      = dir_q;
    assign bus.up_lamp  = up_pend;
    assign bus.dn_lamp  = dn_pend;
    assign bus.car_lamp = car_pend;
    assign bus.fault    = fault_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb/tb_elevator_ctrl_n.sv - directed self-checking bench for elevator_ctrl_n
module tb_elevator_ctrl_n;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] prev_dir = 2'b00;

    always #5 clk = ~clk;

    elevator_if #(.NUM_FLOORS(4)) bus4 ();
    elevator_if #(.NUM_FLOORS(3)) bus3 ();

    elevator_ctrl_n #(.NUM_FLOORS(4), .DOOR_OPEN_CYCLES(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    elevator_ctrl_n #(.NUM_FLOORS(3), .DOOR_OPEN_CYCLES(8)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dd(input string tag, input int door_e, input int dir_e);
        chk({tag, "_door"}, 32'(bus4.door), door_e);
        chk({tag, "_dir"}, 32'(bus4.dir), dir_e);
    endtask

    // Counts open-door samples, holding obstruct for the first k_obs and pulsing dc at dc_at
    task automatic run_door(input int k_obs, input int dc_at, output int n);
        n = 0;
        while (bus4.door && n < 60) begin
            bus4.obstruct = (n < k_obs);
            bus4.dc       = (n == dc_at);
            n++;
            tick();
        end
        bus4.obstruct = 1'b0;
        bus4.dc       = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) chk("dir_no_reversal", 32'((prev_dir ^ bus4.dir) == 2'b11), 0);
        prev_dir = bus4.dir;
    end

    initial begin
        int n;
        rst = 1'b1;
        bus4.hall_up = '0; bus4.hall_dn = '0; bus4.car_call = '0;
        bus4.dc = 1'b0; bus4.obstruct = 1'b0; bus4.fs = 2'd0; bus4.fs_valid = 1'b1;
        bus3.hall_up = '0; bus3.hall_dn = '0; bus3.car_call = '0;
        bus3.dc = 1'b0; bus3.obstruct = 1'b0; bus3.fs = 2'd0; bus3.fs_valid = 1'b1;
        tick(); tick();
        chk_dd("rst", 0, 0);
        chk("rst_car_lamp", 32'(bus4.car_lamp), 0);
        chk("rst_up_lamp", 32'(bus4.up_lamp), 0);
        chk("rst_dn_lamp", 32'(bus4.dn_lamp), 0);
        chk("rst_fault", 32'(bus4.fault), 0);
        chk("rst_fault3", 32'(bus3.fault), 0);
        rst = 1'b0;
        tick();
        chk_dd("idle", 0, 0);

        // 1: reset mid-travel
        bus4.car_call = 4'b0100; tick(); bus4.car_call = '0;
        chk("s1_lamp", 32'(bus4.car_lamp), 'b0100);
        chk("s1_dir", 32'(bus4.dir), 1);
        #2 rst = 1'b1;
        #1;
        chk_dd("s1_async_rst", 0, 0);
        chk("s1_rst_lamp", 32'(bus4.car_lamp), 0);
        @(posedge clk); #1; rst = 1'b0;
        tick();
        chk_dd("s1_after", 0, 0);
        tick();
        chk_dd("s1_after2", 0, 0);

        // 2: car call to top floor
        bus4.car_call = 4'b1000; tick(); bus4.car_call = '0;
        chk("s2_lamp", 32'(bus4.car_lamp), 'b1000);
        chk("s2_dir", 32'(bus4.dir), 1);
        for (int f = 1; f <= 2; f++) begin
            bus4.fs = 2'(f); tick();
            chk_dd("s2_pass", 0, 1);
        end
        bus4.fs = 2'd3; tick();
        chk_dd("s2_stop", 1, 0);
        chk("s2_lamp_clr", 32'(bus4.car_lamp), 0);
        run_door(0, -1, n);
        chk("s2_dwell", n, 8);
        chk_dd("s2_idle", 0, 0);

        // 3: return to 0, then up with hall calls at 2 (up) and 1 (down)
        bus4.car_call = 4'b0001; tick(); bus4.car_call = '0;
        chk("s3_down_dir", 32'(bus4.dir), 2);
        bus4.fs = 2'd2; tick(); bus4.fs = 2'd1; tick(); bus4.fs = 2'd0; tick();
        chk_dd("s3_at0", 1, 0);
        run_door(0, -1, n);
        bus4.car_call = 4'b0100; tick(); bus4.car_call = '0;
        chk("s3_up_dir", 32'(bus4.dir), 1);
        bus4.fs = 2'd1; tick();
        bus4.hall_up = 4'b0100; bus4.hall_dn = 4'b0010; tick();
        bus4.hall_up = '0; bus4.hall_dn = '0;
        chk("s3_up_lamp", 32'(bus4.up_lamp), 'b0100);
        chk("s3_dn_lamp", 32'(bus4.dn_lamp), 'b0010);
        chk_dd("s3_no_stop_1", 0, 1);
        bus4.fs = 2'd2; tick();
        chk_dd("s3_stop2", 1, 0);
        chk("s3_up_clr", 32'(bus4.up_lamp), 0);
        chk("s3_dn_kept", 32'(bus4.dn_lamp), 'b0010);
        run_door(0, -1, n);
        chk("s3_dwell", n, 8);
        chk_dd("s3_reverse", 0, 2);
        bus4.fs = 2'd1; tick();
        chk_dd("s3_stop1", 1, 0);
        chk("s3_dn_served", 32'(bus4.dn_lamp), 0);
        run_door(0, -1, n);
        chk_dd("s3_idle", 0, 0);

        // 4: obstruction then door-close button at floor 2
        bus4.car_call = 4'b0100; tick(); bus4.car_call = '0;
        bus4.fs = 2'd2; tick();
        chk_dd("s4_open", 1, 0);
        run_door(5, -1, n);
        chk("s4_obstruct_dwell", n, 13);
        bus4.car_call = 4'b0100; tick(); bus4.car_call = '0;
        chk_dd("s4_reopen", 1, 0);
        run_door(0, 1, n);
        chk("s4_dc_dwell", n, 2);
        chk_dd("s4_idle", 0, 0);

        // 5: simultaneous calls above and below from floor 1
        bus4.car_call = 4'b0010; tick(); bus4.car_call = '0;
        bus4.fs = 2'd1; tick();
        run_door(0, -1, n);
        bus4.car_call = 4'b1001; tick(); bus4.car_call = '0;
        chk("s5_lamp", 32'(bus4.car_lamp), 'b1001);
        chk_dd("s5_go_up", 0, 1);
        bus4.fs = 2'd2; tick(); bus4.fs = 2'd3; tick();
        chk_dd("s5_stop3", 1, 0);
        chk("s5_lamp3", 32'(bus4.car_lamp), 'b0001);
        run_door(0, -1, n);
        chk("s5_dwell", n, 8);
        chk_dd("s5_then_down", 0, 2);
        bus4.fs = 2'd2; tick(); bus4.fs = 2'd1; tick();
        chk_dd("s5_pass", 0, 2);
        bus4.fs = 2'd0; tick();
        chk_dd("s5_stop0", 1, 0);
        chk("s5_lamp0", 32'(bus4.car_lamp), 0);
        run_door(0, -1, n);
        chk_dd("s5_idle", 0, 0);

        // 6: out-of-range floor sensor on a 3-floor instance
        chk("s6_no_fault", 32'(bus3.fault), 0);
        bus3.fs = 2'd3; tick(); bus3.fs = 2'd0;
        chk("s6_fault", 32'(bus3.fault), 1);
        chk("s6_dir", 32'(bus3.dir), 0);
        bus3.car_call = 3'b100; tick(); bus3.car_call = '0;
        chk("s6_sticky", 32'(bus3.fault), 1);
        chk("s6_latch", 32'(bus3.car_lamp), 'b100);
        tick();
        chk("s6_no_dispatch", 32'(bus3.dir), 0);
        rst = 1'b1; tick();
        chk("s6_rst_fault", 32'(bus3.fault), 0);
        chk("s6_rst_lamp", 32'(bus3.car_lamp), 0);
        rst = 1'b0; tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
